// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default link rates and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_BIT_RATE = 9600;
    localparam int unsigned DEFAULT_CLK_HZ   = 100_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Both divisions truncate, so transmitter and receiver agree on the same period.
    function automatic int unsigned cycles_per_bit(input int unsigned bit_rate,
                                                   input int unsigned clk_hz);
        return (32'd1_000_000_000 / bit_rate) / (32'd1_000_000_000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs (RX pin, buttons).
// Both flops take RESET_VAL so a released reset never looks like an input edge.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the RX pin, qualifies the start bit at mid-bit,
// samples each data bit at its midpoint and checks a single stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned COUNT_W        = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned BITS_W         = $clog2(PAYLOAD_BITS + 1);

    localparam logic [COUNT_W-1:0] HALF_LAST = COUNT_W'(HALF_BIT - 1);
    localparam logic [COUNT_W-1:0] BIT_LAST  = COUNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BITS_W-1:0]  BITS_LAST = BITS_W'(PAYLOAD_BITS - 1);

    uart_state_t             state;
    uart_state_t             state_next;
    logic                    rxd_s;
    logic [COUNT_W-1:0]      cycle_count;
    logic [BITS_W-1:0]       bit_count;
    logic [PAYLOAD_BITS-1:0] shift_reg;

    logic sample;
    logic shift_en;
    logic valid_next;
    logic frame_err_next;
    logic break_next;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (uart_rxd),
        .synced(rxd_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        sample         = 1'b0;
        shift_en       = 1'b0;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        break_next     = 1'b0;
        case (state)
            IDLE: begin
                if (uart_rx_en && !rxd_s) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cycle_count == HALF_LAST) begin
                    sample     = 1'b1;
                    state_next = rxd_s ? IDLE : RECV;
                end
            end
            RECV: begin
                if (cycle_count == BIT_LAST) begin
                    sample   = 1'b1;
                    shift_en = 1'b1;
                    if (bit_count == BITS_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets the next start edge be caught.
                if (cycle_count == BIT_LAST) begin
                    sample         = 1'b1;
                    state_next     = IDLE;
                    valid_next     = rxd_s;
                    frame_err_next = !rxd_s;
                    break_next     = !rxd_s && (shift_reg == '0);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == IDLE || state_next != state || sample) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count <= '0;
        end else if (state != RECV) begin
            bit_count <= '0;
        end else if (shift_en) begin
            bit_count <= bit_count + BITS_W'(1);
        end
    end

    // Right shift: the first bit received ends up in bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {rxd_s, shift_reg[PAYLOAD_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            uart_rx_data      <= '0;
        end else begin
            uart_rx_valid     <= valid_next;
            uart_rx_frame_err <= frame_err_next;
            uart_rx_break     <= break_next;
            if (valid_next) begin
                uart_rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic,
// checked every cycle against a sample-offset model of the receive rules.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned BIT_RATE = 20_000;
    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int P    = 8;
    localparam int CPB  = 50;   // (1e9/20000)/(1e9/1e6) = 50000/1000
    localparam int HALF = 25;

    logic         clk;
    logic         reset;
    logic         uart_rxd;
    logic         uart_rx_en;
    logic         uart_rx_valid;
    logic [P-1:0] uart_rx_data;
    logic         uart_rx_frame_err;
    logic         uart_rx_break;

    uart_rx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(P)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_break    (uart_rx_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Model: receiver decisions by offset from the first low cycle of the synchronised line.
    bit         m_idle = 1'b1;
    int         m_t0   = 0;
    bit [P-1:0] m_bits = '0;
    bit [P-1:0] m_data = '0;
    bit         pend_v = 1'b0, pend_e = 1'b0, pend_b = 1'b0;
    bit [P-1:0] pend_d = '0;
    bit         pin_d1 = 1'b1, pin_d2 = 1'b1, rst_d1 = 1'b1, rst_d2 = 1'b1;

    int         n_valid = 0, n_err = 0, n_brk = 0, last_valid_cyc = 0;
    bit [P-1:0] last_data = '0;
    bit [P-1:0] prev_data = '0;

    always @(negedge clk) begin
        bit rs;
        bit ev, ee, eb;
        int off, idx;
        rs = (rst_d1 || rst_d2) ? 1'b1 : pin_d2;
        if (reset) begin
            ev = 1'b0; ee = 1'b0; eb = 1'b0;
            m_data = '0;
            m_idle = 1'b1;
        end else begin
            ev = pend_v; ee = pend_e; eb = pend_b;
            if (pend_v) m_data = pend_d;
        end
        pend_v = 1'b0; pend_e = 1'b0; pend_b = 1'b0;

        check("valid", int'(uart_rx_valid), int'(ev));
        check("frame_err", int'(uart_rx_frame_err), int'(ee));
        check("break", int'(uart_rx_break), int'(eb));
        check("data", int'(uart_rx_data), int'(m_data));
        check("valid_err_exclusive", int'(uart_rx_valid & uart_rx_frame_err), 0);
        check("data_hold", int'((uart_rx_data != prev_data) && !uart_rx_valid && !reset), 0);

        if (uart_rx_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            last_data      = uart_rx_data;
        end
        if (uart_rx_frame_err) n_err++;
        if (uart_rx_break) n_brk++;
        prev_data = uart_rx_data;

        if (!reset) begin
            if (m_idle) begin
                if (uart_rx_en && !rs) begin
                    m_idle = 1'b0;
                    m_t0   = cyc;
                end
            end else begin
                off = cyc - m_t0;
                if (off == HALF) begin
                    if (rs) m_idle = 1'b1;
                end else if (off > HALF && (off - HALF) % CPB == 0) begin
                    idx = (off - HALF) / CPB;
                    if (idx <= P) begin
                        m_bits[idx-1] = rs;
                    end else begin
                        if (rs) begin
                            pend_v = 1'b1;
                            pend_d = m_bits;
                        end else begin
                            pend_e = 1'b1;
                            pend_b = (m_bits == '0);
                        end
                        m_idle = 1'b1;
                    end
                end
            end
        end
        pin_d2 = pin_d1; pin_d1 = uart_rxd;
        rst_d2 = rst_d1; rst_d1 = reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [P-1:0] d, input bit stop, input int period);
        uart_rxd = 1'b0;
        tick(period);
        for (int i = 0; i < P; i++) begin
            uart_rxd = d[i];
            tick(period);
        end
        uart_rxd = stop;
        tick(period);
        uart_rxd = 1'b1;
    endtask

    initial begin
        #(10 * 90_000);
        $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nv, ne, nb;
        logic [P-1:0] d;
        reset      = 1'b1;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(20);
        check("reset_data", int'(uart_rx_data), 0);
        check("reset_valid", int'(uart_rx_valid), 0);

        // Single byte: pin fall to pulse = 2 (sync) + 1 + 25 + 9*50 = 478 cycles.
        nv = n_valid; ne = n_err; base = cyc;
        send_frame(8'hA5, 1'b1, CPB);
        tick(100);
        check("a5_count", n_valid - nv, 1);
        check("a5_latency", last_valid_cyc - base, 478);
        check("a5_data", int'(last_data), 'hA5);
        check("a5_no_err", n_err - ne, 0);

        nv = n_valid; ne = n_err;
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        send_frame(8'h3C, 1'b1, CPB);
        tick(100);
        check("b2b_count", n_valid - nv, 3);
        check("b2b_last", int'(last_data), 'h3C);
        check("b2b_no_err", n_err - ne, 0);

        nv = n_valid; ne = n_err;
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(60);
        check("glitch_silent", n_valid - nv, 0);
        send_frame(8'h5A, 1'b1, CPB);
        tick(100);
        check("glitch_then_count", n_valid - nv, 1);
        check("glitch_then_data", int'(last_data), 'h5A);
        check("glitch_no_err", n_err - ne, 0);

        nv = n_valid; ne = n_err; nb = n_brk;
        send_frame(8'h81, 1'b0, CPB);
        tick(100);
        check("ferr_count", n_err - ne, 1);
        check("ferr_no_break", n_brk - nb, 0);
        check("ferr_data_kept", int'(uart_rx_data), 'h5A);
        send_frame(8'h00, 1'b0, CPB);
        tick(100);
        check("break_err_count", n_err - ne, 2);
        check("break_count", n_brk - nb, 1);
        check("break_no_valid", n_valid - nv, 0);

        nv = n_valid;
        send_frame(8'h55, 1'b1, CPB + 1);
        tick(100);
        check("skew_slow_data", int'(last_data), 'h55);
        send_frame(8'h55, 1'b1, CPB - 1);
        tick(100);
        check("skew_count", n_valid - nv, 2);

        nv = n_valid; ne = n_err;
        uart_rx_en = 1'b0;
        send_frame(8'h77, 1'b1, CPB);
        tick(50);
        uart_rx_en = 1'b1;
        tick(100);
        check("disabled_no_valid", n_valid - nv, 0);
        check("disabled_no_err", n_err - ne, 0);

        nv = n_valid;
        fork
            send_frame(8'h96, 1'b1, CPB);
            begin
                tick(150);
                uart_rx_en = 1'b0;
            end
        join
        tick(100);
        uart_rx_en = 1'b1;
        check("en_drop_count", n_valid - nv, 1);
        check("en_drop_data", int'(last_data), 'h96);

        nv = n_valid;
        uart_rxd = 1'b0; tick(CPB);
        uart_rxd = 1'b1; tick(CPB);
        uart_rxd = 1'b0; tick(100);
        reset = 1'b1;
        #1;
        check("rst_async_data", int'(uart_rx_data), 0);
        check("rst_async_valid", int'(uart_rx_valid), 0);
        uart_rxd = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(100);
        send_frame(8'hC3, 1'b1, CPB);
        tick(100);
        check("after_rst_count", n_valid - nv, 1);
        check("after_rst_data", int'(last_data), 'hC3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                uart_rxd = 1'b0;
                tick($urandom_range(20, 1));
                uart_rxd = 1'b1;
                tick($urandom_range(40, 5));
            end
            uart_rx_en = ($urandom_range(5, 0) != 0);
            d = P'($urandom);
            send_frame(d, ($urandom_range(4, 0) != 0), $urandom_range(CPB + 1, CPB - 1));
            tick($urandom_range(120, 0));
            uart_rx_en = 1'b1;
        end
        tick(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
